// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// One-cycle request strobe, single-strobe response per request.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM, IF/ID register.
// Redirects drop in-flight responses; a stalled response parks in HOLD.
module fetch_unit (
  input  logic                clk,
  input  logic                reset,
  input  logic                stallF,
  input  logic                stallD,
  input  logic                pcsrcD,
  input  logic [31:0]         pcbranchD,
  fetch_unit_if.master        imem,
  output logic [31:0]         instrD,
  output logic [31:0]         pcplus4D,
  output logic                validD,
  output logic                imissF
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DISC
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        redir;
  logic [31:0] pcplus4F;

  assign redir    = pcsrcD & ~stallD;
  assign pcplus4F = pc_q + 32'd4;

  // Gated by reset so the strobe drops without waiting for a clock.
  assign imem.imem_req  = (state_q == S_REQ) & ~stallF & ~reset;
  assign imem.imem_addr = pc_q;

  assign imissF = (state_q == S_REQ) | (state_q == S_DISC) |
                  ((state_q == S_WAIT) & ~imem.imem_rvalid);

  assign instrD   = instr_q;
  assign pcplus4D = pcp4_q;
  assign validD   = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (!stallD) begin
      instr_d = 32'h0;
      valid_d = 1'b0;
    end
    unique case (state_q)
      S_REQ: begin
        if (!stallF) state_d = redir ? S_DISC : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (redir) begin
            state_d = S_REQ;
          end else if (stallD) begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            instr_d = imem.imem_rdata;
            valid_d = 1'b1;
            pcp4_d  = pcplus4F;
            pc_d    = pcplus4F;
            state_d = S_REQ;
          end
        end else if (redir) begin
          state_d = S_DISC;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
        end else if (!stallD) begin
          instr_d = buf_q;
          valid_d = 1'b1;
          pcp4_d  = pcplus4F;
          pc_d    = pcplus4F;
          state_d = S_REQ;
        end
      end
      S_DISC: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redir) pc_d = pcbranchD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= 32'h0;
      buf_q   <= 32'h0;
      instr_q <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus scoreboard of expected
// IF/ID deliveries, with directed corner cases and a random phase.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, pcsrcD;
  logic [31:0] pcbranchD;
  logic [31:0] instrD, pcplus4D;
  logic        validD, imissF;

  fetch_unit_if imem();

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stallF    (stallF),
    .stallD    (stallD),
    .pcsrcD    (pcsrcD),
    .pcbranchD (pcbranchD),
    .imem      (imem),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .validD    (validD),
    .imissF    (imissF)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc, pend_addr, resp_addr;
  logic [31:0] held_i, held_p, mi, mp;
  logic        mv, pend, drop, has_held;
  int          cnt, lat_lo, lat_hi, n_req;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0)  return 32'h20080005;
    if (a == 32'h10) return 32'hAABBCCDD;
    return a ^ 32'h13579BDF;
  endfunction

  task automatic model_reset();
    sb.delete();
    exp_pc = 0; mi = 0; mp = 0; mv = 0;
    pend = 0; drop = 0; has_held = 0; cnt = 0;
    resp_addr = 0; pend_addr = 0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    stallF = 0; stallD = 0; pcsrcD = 0; pcbranchD = 0;
  endtask

  task automatic tick();
    logic        redir, req_seen, deliver, ld;
    logic [31:0] req_pc;
    exp_t        e;
    #1;
    redir    = pcsrcD & ~stallD;
    req_seen = imem.imem_req;
    req_pc   = exp_pc;
    deliver  = 1'b0;
    if (req_seen) begin
      n_req++;
      chk("imem_addr", imem.imem_addr, exp_pc);
      chk("one_outstanding", {31'b0, pend | imem.imem_rvalid}, 32'h0);
    end
    if (has_held && redir) has_held = 1'b0;
    if (imem.imem_rvalid) begin
      if (!(drop || redir)) begin
        held_i   = mem(resp_addr);
        held_p   = resp_addr + 32'd4;
        has_held = 1'b1;
      end
      drop = 1'b0;
    end
    if (has_held && !stallD) begin
      sb.push_back('{held_i, held_p});
      deliver  = 1'b1;
      has_held = 1'b0;
      exp_pc   = exp_pc + 32'd4;
    end
    if (redir) begin
      if (req_seen || pend) drop = 1'b1;
      exp_pc = pcbranchD;
    end
    ld = !stallD;
    @(posedge clk);
    #1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    if (req_seen) begin
      pend      = 1'b1;
      pend_addr = req_pc;
      cnt       = int'($urandom_range(lat_hi, lat_lo));
    end
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        pend             = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = mem(pend_addr);
        resp_addr        = pend_addr;
      end
    end
    @(negedge clk);
    #1;
    if (ld) begin
      if (deliver && sb.size() > 0) begin
        e  = sb.pop_front();
        mi = e.instr;
        mp = e.pcp4;
        mv = 1'b1;
      end else begin
        mi = 32'h0;
        mv = 1'b0;
      end
    end
    chk("validD", {31'b0, validD}, {31'b0, mv});
    chk("instrD", instrD, mi);
    chk("pcplus4D", pcplus4D, mp);
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!imem.imem_req && k < 50) begin
      tick();
      k++;
    end
    chk(tag, {31'b0, imem.imem_req}, 32'h1);
  endtask

  initial begin
    reset  = 1'b1;
    model_reset();
    lat_lo = 1;
    lat_hi = 1;
    n_req  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_validD", {31'b0, validD}, 32'h0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("first_req", {31'b0, imem.imem_req}, 32'h1);
    chk("first_addr", imem.imem_addr, 32'h0);

    repeat (2) tick();
    chk("c3_instrD", instrD, 32'h20080005);
    chk("c3_pcplus4D", pcplus4D, 32'h4);
    chk("c3_validD", {31'b0, validD}, 32'h1);
    chk("c3_addr", imem.imem_addr, 32'h4);
    repeat (6) tick();
    chk("throughput", 32'(n_req), 32'd4);

    wait_req("req_10");
    chk("stall_addr", imem.imem_addr, 32'h10);
    stallD = 1'b1;
    repeat (3) tick();
    chk("hold_req", {31'b0, imem.imem_req}, 32'h0);
    chk("hold_imiss", {31'b0, imissF}, 32'h0);
    stallD = 1'b0;
    tick();
    chk("hold_instrD", instrD, 32'hAABBCCDD);
    chk("hold_validD", {31'b0, validD}, 32'h1);
    chk("hold_next_addr", imem.imem_addr, 32'h14);

    lat_lo = 3;
    lat_hi = 3;
    wait_req("req_wait");
    tick();
    pcsrcD    = 1'b1;
    pcbranchD = 32'h40;
    tick();
    pcsrcD = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    wait_req("req_redir");
    chk("redir_addr", imem.imem_addr, 32'h40);

    stallF = 1'b1;
    repeat (4) begin
      #1;
      chk("stallF_req", {31'b0, imem.imem_req}, 32'h0);
      chk("stallF_imiss", {31'b0, imissF}, 32'h1);
      tick();
    end
    stallF = 1'b0;
    #1 chk("stallF_addr", imem.imem_addr, 32'h40);

    pcsrcD    = 1'b1;
    pcbranchD = 32'h80;
    tick();
    pcsrcD = 1'b0;
    wait_req("req_samecyc");
    chk("samecyc_addr", imem.imem_addr, 32'h80);

    stallF    = 1'b1;
    pcsrcD    = 1'b1;
    pcbranchD = 32'hFFFFFFFC;
    tick();
    stallF = 1'b0;
    pcsrcD = 1'b0;
    #1 chk("wrap_addr", imem.imem_addr, 32'hFFFFFFFC);
    repeat (2) tick();
    chk("wrap_pcplus4D", pcplus4D, 32'h0);
    chk("wrap_validD", {31'b0, validD}, 32'h1);
    chk("wrap_next", imem.imem_addr, 32'h0);

    lat_lo = 1;
    lat_hi = 3;
    repeat (300) begin
      stallF    = ($urandom_range(4, 0) == 0);
      stallD    = ($urandom_range(3, 0) == 0);
      pcsrcD    = ($urandom_range(9, 0) == 0);
      pcbranchD = $urandom() & 32'hFFFFFFFC;
      tick();
    end
    stallF = 1'b0;
    stallD = 1'b0;
    pcsrcD = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    repeat (8) tick();

    wait_req("req_hold_rst");
    stallD = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_validD", {31'b0, validD}, 32'h0);
    chk("mid_rst_instrD", instrD, 32'h0);
    chk("mid_rst_pcplus4D", pcplus4D, 32'h0);
    chk("mid_rst_req", {31'b0, imem.imem_req}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req", {31'b0, imem.imem_req}, 32'h1);
    chk("post_rst_addr", imem.imem_addr, 32'h0);
    repeat (4) tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 stallF  in  1  hold PC / suppress new instruction-memory request.
REQ-004 stallD  in  1  hold IF/ID register contents.
REQ-005 pcsrcD  in  1  taken branch/jump resolved in Decode; redirect fetch.
REQ-006 pcbranchD  in  32  redirect target, word-aligned.
REQ-007 imem_req  out  1  one-cycle request strobe.
REQ-008 imem_addr  out  32  fetch address, valid when imem_req=1.
REQ-009 imem_rvalid  in  1  response strobe, exactly one per request, earliest 1 cycle after imem_req.
REQ-010 imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
REQ-011 instrD  out  32  IF/ID instruction.
REQ-012 pcplus4D  out  32  IF/ID PC+4 of instrD.
REQ-013 validD  out  1  instrD is a real instruction (0 = bubble).
REQ-014 imissF  out  1  fetch has no instruction available this cycle (perf/debug).

Function
REQ-015 Internal state: pcF (32), FSM {REQ, WAIT, HOLD, DISCARD}, 32-bit hold buffer.
REQ-016 REQ: stallF=0 -> imem_req=1, imem_addr=pcF, next WAIT; stallF=1 -> no request, stay REQ.
REQ-017 imem_req SHALL be 0 in all states other than REQ; at most one request outstanding.
REQ-018 WAIT, imem_rvalid=1, stallD=0: instrD<=imem_rdata, pcplus4D<=pcF+4, validD<=1, pcF<=pcF+4, next REQ.
REQ-019 WAIT, imem_rvalid=1, stallD=1: buffer<=imem_rdata, IF/ID unchanged, next HOLD.
REQ-020 WAIT, imem_rvalid=0: stay WAIT.
REQ-021 HOLD, stallD=0: IF/ID<=buffer (validD=1, pcplus4D=pcF+4), pcF<=pcF+4, next REQ; stallD=1: stay HOLD.
REQ-022 Any cycle IF/ID is not loaded per REQ-018/021 and stallD=0: IF/ID loads bubble (instrD=0, validD=0, pcplus4D unchanged).
REQ-023 Redirect = pcsrcD & ~stallD; priority reset > redirect > stallD > normal.
REQ-024 Redirect: pcF<=pcbranchD, IF/ID<=bubble; from REQ or HOLD -> REQ (buffer discarded); from WAIT with imem_rvalid=0 -> DISCARD; from WAIT with imem_rvalid=1 -> response dropped, next REQ.
REQ-025 Redirect in REQ same cycle as imem_req: request completes to WAIT-equivalent DISCARD; its response SHALL be dropped.
REQ-026 DISCARD: on imem_rvalid, drop data, next REQ; further redirects in DISCARD update pcF only.
REQ-027 imissF=1 in REQ, DISCARD, and WAIT with imem_rvalid=0; else 0.
REQ-028 pcF+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-029 Minimum throughput: one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-030 reset=1: pcF=0x00000000, state=REQ, buffer=0, instrD=0, pcplus4D=0, validD=0, imem_req=0 asynchronously.
REQ-031 Reset asserted with a request outstanding: the pending response after reset release is not guaranteed; the memory SHALL be reset together with this block.
REQ-032 First imem_req issued in the first cycle after reset deasserts with imem_addr=0x00000000 (if stallF=0).

Verification
REQ-033 Reset release, 1-cycle memory returning 0x20080005 at addr 0 -> imem_req at cycle 1, instrD=0x20080005, pcplus4D=0x4, validD=1 at cycle 3; next imem_addr=0x4.
REQ-034 stallD=1 for 3 cycles while response 0xAABBCCDD arrives -> state HOLD, IF/ID unchanged; after release instrD=0xAABBCCDD, validD=1, no second request for same PC.
REQ-035 pcsrcD=1, pcbranchD=0x40 while in WAIT, response arrives 2 cycles later -> response dropped, validD=0 bubble, next imem_addr=0x40.
REQ-036 stallF=1 in REQ for 4 cycles -> imem_req=0 throughout, imissF=1, pcF unchanged.
REQ-037 pcF=0xFFFFFFFC fetch delivered -> pcplus4D=0x00000000, next imem_addr=0x00000000.
REQ-038 reset asserted mid-HOLD -> all outputs at REQ-030 values immediately, without waiting for clk.
